// File: rtl/digital_theremin_clk_pkg.sv
// Shared constants, width helpers and config request type for the theremin
// clock-enable generator.
package digital_theremin_clk_pkg;

    localparam int unsigned MIN_DIV    = 2;
    localparam int unsigned DEF_DIV_W  = 16;
    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned MAX_CH_W   = 4;

    // Channel select width; a single channel still gets one select bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lock counter must be able to hold the value n itself.
    function automatic int unsigned lock_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic [MAX_CH_W-1:0]  ch;
        logic [DEF_DIV_W-1:0] div;
    } cfg_req_t;

endpackage

// File: rtl/digital_theremin_clk_div_ch.sv
// One divider channel: period counter, active and pending ratio, registered
// enable strobe and square output. New ratios take effect only at a wrap or
// on a sync, so a running period is never cut short.
module digital_theremin_clk_div_ch
    import digital_theremin_clk_pkg::*;
#(
    parameter int unsigned DIV_W    = DEF_DIV_W,
    parameter int unsigned DIV_INIT = 4
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pending,
    output logic             ce,
    output logic             clk_div,
    output logic             apply_pulse
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             ce_q, ce_d;
    logic             clk_q, clk_d;
    logic             wrap;
    logic [DIV_W:0]   half;

    assign wrap = (cnt_q == (div_q - DIV_W'(1)));
    // Extra bit so D+1 cannot overflow at the top of the ratio range.
    assign half = ({1'b0, div_q} + (DIV_W + 1)'(1)) >> 1;

    // Next-state: count, wrap/sync handling, ratio apply and pending capture.
    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        pend_d      = pend_q;
        pending_d   = pending_q;
        ce_d        = 1'b0;
        clk_d       = clk_q;
        apply_pulse = 1'b0;
        if (en) begin
            clk_d = ({1'b0, cnt_q} < half);
            if (sync || wrap) begin
                cnt_d = '0;
                ce_d  = !sync;
                if (pending_q) begin
                    div_d       = pend_q;
                    pending_d   = 1'b0;
                    apply_pulse = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        // A write is only offered while nothing is pending, so it never
        // collides with an apply in the same cycle.
        if (wr) begin
            pend_d    = wr_div;
            pending_d = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= DIV_W'(DIV_INIT);
            pend_q    <= '0;
            pending_q <= 1'b0;
            ce_q      <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            ce_q      <= ce_d;
            clk_q     <= clk_d;
        end
    end

    assign pending = pending_q;
    assign ce      = ce_q;
    assign clk_div = clk_q;

endmodule

// File: rtl/digital_theremin_clk_en_gen.sv
// Multi-channel clock-enable generator: config decode and error flag, sync
// fan-out, per-channel dividers and the lock indication.
module digital_theremin_clk_en_gen
    import digital_theremin_clk_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned DIV_W       = DEF_DIV_W,
    parameter int unsigned DIV_INIT    = 4,
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic                        refclk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        sync_req,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic                        cfg_err,
    output logic [NUM_CH-1:0]           ce_out,
    output logic [NUM_CH-1:0]           clk_out,
    output logic                        locked
);

    localparam int unsigned CH_W   = ch_width(NUM_CH);
    localparam int unsigned LOCK_W = lock_width(LOCK_CYCLES);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] wr;
    logic              ch_ok;
    logic              sel_pending;
    logic              div_ok;
    logic              accept;
    logic              err_d;
    logic              cfg_err_q;
    logic              sync_en;
    logic              restart;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    // Channel decode; out-of-range selects see no pending and are accepted.
    always_comb begin
        ch_ok       = 1'b0;
        sel_pending = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ch_ok       = 1'b1;
                sel_pending = pending[i];
            end
        end
    end

    assign cfg_ready = !sel_pending;
    assign div_ok    = (cfg_div >= DIV_W'(MIN_DIV));
    assign accept    = cfg_valid & cfg_ready;
    assign err_d     = accept & !(ch_ok & div_ok);
    assign sync_en   = sync_req & en;
    assign restart   = sync_en | (|apply);

    // Per-channel write strobes for accepted legal requests.
    always_comb begin
        wr = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            wr[i] = accept & ch_ok & div_ok & (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        digital_theremin_clk_div_ch #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .refclk      (refclk),
            .rst_n       (rst_n),
            .en          (en),
            .sync        (sync_en),
            .wr          (wr[g]),
            .wr_div      (cfg_div),
            .pending     (pending[g]),
            .ce          (ce_out[g]),
            .clk_div     (clk_out[g]),
            .apply_pulse (apply[g])
        );
    end

    // Lock counter: restart has priority over reaching the settle count.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (restart) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (en && !locked_q) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            if (lock_cnt_d == LOCK_W'(LOCK_CYCLES)) begin
                locked_d = 1'b1;
            end
        end
    end

    // Lock and error registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            cfg_err_q  <= err_d;
        end
    end

    assign locked  = locked_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_digital_theremin_clk_en_gen.sv
// Directed bench for the clock-enable generator. Inputs change and outputs
// are sampled on the falling edge of refclk.
module tb_digital_theremin_clk_en_gen;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sync_req;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_err;
    logic [3:0]  ce_out;
    logic [3:0]  clk_out;
    logic        locked;

    // Second instance with a non-power-of-two channel count so that an
    // out-of-range channel select is expressible.
    logic        zero = 1'b0;
    logic        cfg_valid5;
    logic        cfg_ready5;
    logic [2:0]  cfg_ch5;
    logic [15:0] cfg_div5;
    logic        cfg_err5;
    logic [4:0]  ce_out5;
    logic [4:0]  clk_out5;
    logic        locked5;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    digital_theremin_clk_en_gen #(
        .NUM_CH      (4),
        .DIV_W       (16),
        .DIV_INIT    (4),
        .LOCK_CYCLES (1024)
    ) u_dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_req  (sync_req),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .ce_out    (ce_out),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    digital_theremin_clk_en_gen #(
        .NUM_CH      (5),
        .DIV_W       (16),
        .DIV_INIT    (4),
        .LOCK_CYCLES (4)
    ) u_dut5 (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_req  (zero),
        .cfg_valid (cfg_valid5),
        .cfg_ready (cfg_ready5),
        .cfg_ch    (cfg_ch5),
        .cfg_div   (cfg_div5),
        .cfg_err   (cfg_err5),
        .ce_out    (ce_out5),
        .clk_out   (clk_out5),
        .locked    (locked5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge refclk);
    endtask

    initial begin
        logic [3:0] ce_exp;
        logic [3:0] clk_exp;
        logic       found;

        rst_n      = 1'b0;
        en         = 1'b0;
        sync_req   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_div    = 16'd0;
        cfg_valid5 = 1'b0;
        cfg_ch5    = 3'd0;
        cfg_div5   = 16'd0;
        tick();
        tick();
        check("rst_ce", ce_out, 4'h0);
        check("rst_clk", clk_out, 4'h0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);

        // Defaults: D=4 on every channel, lock after 1024 enabled edges.
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 1024; k++) begin
            tick();
            if (k <= 12) begin
                check("a_ce", ce_out, (k % 4 == 0) ? 4'hF : 4'h0);
                check("a_clk", clk_out, ((k - 1) % 4 < 2) ? 4'hF : 4'h0);
            end
            if (k == 1023) check("a_locked_early", locked, 1'b0);
            if (k == 1024) check("a_locked", locked, 1'b1);
        end

        // ch1 -> D=7 written at cnt=1; old period completes first.
        tick();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd7;
        #1 check("b_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        #1 check("b_ready_pend", cfg_ready, 1'b0);
        tick();
        check("b_ce_mid", ce_out, 4'h0);
        check("b_locked_hold", locked, 1'b1);
        tick();
        check("b_ce_wrap", ce_out, 4'hF);
        check("b_locked_drop", locked, 1'b0);
        check("b_ready_after", cfg_ready, 1'b1);
        for (int j = 1; j <= 1024; j++) begin
            tick();
            if (j <= 14) begin
                check("b_ce1", ce_out[1], (j % 7 == 0));
                check("b_clk1", clk_out[1], ((j - 1) % 7 < 4));
            end
            if (j == 1023) check("b_locked_early", locked, 1'b0);
            if (j == 1024) check("b_relock", locked, 1'b1);
        end

        // Back-to-back ch2 writes; ch3 accepted in the same window.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 16'd9;
        #1 check("c_ready_ch2", cfg_ready, 1'b1);
        tick();
        cfg_div = 16'd5;
        #1 check("c_busy_ch2", cfg_ready, 1'b0);
        tick();
        cfg_ch  = 2'd3;
        cfg_div = 16'd8;
        #1 check("c_ready_ch3", cfg_ready, 1'b1);
        tick();
        cfg_ch  = 2'd2;
        cfg_div = 16'd5;
        #1 check("c_busy_ch2_b", cfg_ready, 1'b0);
        tick();
        check("c_ce_wrap", ce_out, 4'b1101);
        check("c_locked_drop", locked, 1'b0);
        check("c_ready_ch2_free", cfg_ready, 1'b1);
        // ch1 wraps on this edge with nothing pending: write must be deferred.
        cfg_ch  = 2'd1;
        cfg_div = 16'd10;
        #1 check("c_ready_ch1", cfg_ready, 1'b1);
        tick();
        check("c_ce_ch1_wrap", ce_out, 4'b0010);
        #1 check("c_ch1_pending", cfg_ready, 1'b0);
        cfg_ch  = 2'd2;
        cfg_div = 16'd5;
        #1 check("c_ready_ch2_c", cfg_ready, 1'b1);
        tick();
        cfg_ch  = 2'd0;
        cfg_div = 16'd3;
        tick();
        // sync together with a ch3 write: sync wins, write stays pending.
        cfg_ch   = 2'd3;
        cfg_div  = 16'd6;
        sync_req = 1'b1;
        #1 check("d_ready_ch3", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        sync_req  = 1'b0;
        check("d_ce_sync", ce_out, 4'h0);
        #1 check("d_ch3_pending", cfg_ready, 1'b0);
        cfg_ch = 2'd1;
        #1 check("d_ch1_cleared", cfg_ready, 1'b1);
        for (int j = 1; j <= 1032; j++) begin
            tick();
            if (j <= 14) begin
                ce_exp[0]  = (j % 3 == 0);
                ce_exp[1]  = (j % 10 == 0);
                ce_exp[2]  = (j % 5 == 0);
                ce_exp[3]  = (j == 8) || (j > 8 && (j - 8) % 6 == 0);
                clk_exp[0] = ((j - 1) % 3 < 2);
                clk_exp[1] = ((j - 1) % 10 < 5);
                clk_exp[2] = ((j - 1) % 5 < 3);
                clk_exp[3] = (j <= 8) ? ((j - 1) % 8 < 4) : ((j - 9) % 6 < 3);
                check("d_ce", ce_out, ce_exp);
                check("d_clk", clk_out, clk_exp);
            end
            if (j == 1031) check("d_locked_early", locked, 1'b0);
            if (j == 1032) check("d_relock", locked, 1'b1);
        end

        // Illegal ratio on ch0.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd1;
        #1 check("e_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        check("e_err_pulse", cfg_err, 1'b1);
        check("e_locked", locked, 1'b1);
        #1 check("e_no_pending", cfg_ready, 1'b1);
        tick();
        check("e_err_clear", cfg_err, 1'b0);
        check("e_locked_b", locked, 1'b1);

        // Out-of-range channel on the five-channel instance.
        cfg_valid5 = 1'b1;
        cfg_ch5    = 3'd5;
        cfg_div5   = 16'd3;
        #1 check("e5_ready", cfg_ready5, 1'b1);
        tick();
        cfg_valid5 = 1'b0;
        check("e5_err_pulse", cfg_err5, 1'b1);
        check("e5_locked", locked5, 1'b1);
        tick();
        check("e5_err_clear", cfg_err5, 1'b0);

        // ch0 must still be running at D=3.
        found = 1'b0;
        for (int w = 0; w < 4 && !found; w++) begin
            tick();
            if (ce_out[0]) found = 1'b1;
        end
        check("e_ce0_found", found, 1'b1);
        for (int t = 1; t <= 3; t++) begin
            tick();
            check("e_ce0_period", ce_out[0], (t == 3));
        end

        // Freeze mid-period with en=0, then resume from the held count.
        tick();
        check("f_clk0_pre", clk_out[0], 1'b1);
        en = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            check("f_ce_frozen", ce_out, 4'h0);
            check("f_clk0_frozen", clk_out[0], 1'b1);
            check("f_locked_frozen", locked, 1'b1);
        end
        en = 1'b1;
        tick();
        check("f_resume_ce0_a", ce_out[0], 1'b0);
        check("f_resume_clk0_a", clk_out[0], 1'b1);
        tick();
        check("f_resume_ce0_b", ce_out[0], 1'b1);
        check("f_resume_clk0_b", clk_out[0], 1'b0);

        // Leave a pending write on ch2, then pulse the async reset.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 16'd7;
        #1 check("g_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        #1 check("g_pending", cfg_ready, 1'b0);
        check("g_clk0_pre", clk_out[0], 1'b1);
        check("g_locked_pre", locked, 1'b1);
        rst_n = 1'b0;
        #1;
        check("g_rst_ce", ce_out, 4'h0);
        check("g_rst_clk", clk_out, 4'h0);
        check("g_rst_locked", locked, 1'b0);
        check("g_rst_err", cfg_err, 1'b0);
        check("g_rst_ready", cfg_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("g_ce_after_rst", ce_out, (k % 4 == 0) ? 4'hF : 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
